// File: rtl/stack_pkg.sv
// Shared definitions for the call/return sequencer: FSM state encoding and
// default stack window bounds.
package stack_pkg;

  localparam logic [15:0] SP_TOP_DEFAULT   = 16'h018F;
  localparam logic [15:0] SP_LIMIT_DEFAULT = 16'h0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2
  } state_e;

endpackage

// File: rtl/call_return_unit_if.sv
// Data-memory port between the call/return sequencer (master) and memory (slave).
interface call_return_unit_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/call_stack_sp.sv
// Architectural stack pointer: resets to SP_TOP, moves by one on inc/dec,
// and flags the empty (SP_TOP) and full (SP_LIMIT-1) positions.
module call_stack_sp
  import stack_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] SP_TOP   = SP_TOP_DEFAULT,
  parameter logic [ADDR_W-1:0] SP_LIMIT = SP_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [ADDR_W-1:0] sp_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam logic [ADDR_W-1:0] SP_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SP_FULL = SP_LIMIT - SP_ONE;

  logic [ADDR_W-1:0] sp_q, sp_d;

  always_comb begin
    sp_d = sp_q;
    if (inc_i) begin
      sp_d = sp_q + SP_ONE;
    end else if (dec_i) begin
      sp_d = sp_q - SP_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= SP_TOP;
    end else begin
      sp_q <= sp_d;
    end
  end

  assign sp_o    = sp_q;
  assign full_o  = (sp_q == SP_FULL);
  assign empty_o = (sp_q == SP_TOP);
endmodule

// File: rtl/call_return_unit.sv
// CALL/RET sequencer: pushes return addresses to and pops them from data memory.
// Optional feature macro: STACK_BOUNDS_CHECK_EN (rejects push on full / pop on empty).
module call_return_unit
  import stack_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] SP_TOP   = SP_TOP_DEFAULT,
  parameter logic [ADDR_W-1:0] SP_LIMIT = SP_LIMIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 call_req,
  input  logic                 ret_req,
  input  logic [ADDR_W-1:0]    ret_addr_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pc_load,
  output logic [ADDR_W-1:0]    pc_target,
  output logic [ADDR_W-1:0]    sp_out,
  output logic                 overflow,
  output logic                 underflow,
  call_return_unit_if.master   mem
);
  localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] pc_target_q, pc_target_d;
  logic              done_q, done_d;
  logic              pc_load_q, pc_load_d;
  logic              sp_inc, sp_dec, sp_full, sp_empty;
  logic [ADDR_W-1:0] sp;
`ifdef STACK_BOUNDS_CHECK_EN
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
`endif

  call_stack_sp #(
    .ADDR_W   (ADDR_W),
    .SP_TOP   (SP_TOP),
    .SP_LIMIT (SP_LIMIT)
  ) u_sp (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (sp_inc),
    .dec_i   (sp_dec),
    .sp_o    (sp),
    .full_o  (sp_full),
    .empty_o (sp_empty)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pc_target_d = pc_target_q;
    done_d      = 1'b0;
    pc_load_d   = 1'b0;
    sp_inc      = 1'b0;
    sp_dec      = 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // Call has priority over ret when both arrive together.
        if (call_req) begin
`ifdef STACK_BOUNDS_CHECK_EN
          if (sp_full) begin
            overflow_d = 1'b1;
            done_d     = 1'b1;
          end else
`endif
          begin
            mem_wdata_d = ret_addr_in;
            mem_addr_d  = sp;
            mem_we_d    = 1'b1;
            mem_req_d   = 1'b1;
            state_d     = PUSH;
          end
        end else if (ret_req) begin
`ifdef STACK_BOUNDS_CHECK_EN
          if (sp_empty) begin
            underflow_d = 1'b1;
            done_d      = 1'b1;
          end else
`endif
          begin
            mem_addr_d = sp + SP_ONE;
            mem_we_d   = 1'b0;
            mem_req_d  = 1'b1;
            state_d    = POP;
          end
        end
      end
      PUSH: begin
        if (mem_req_q && mem.mem_ack) begin
          mem_req_d = 1'b0;
          sp_dec    = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      POP: begin
        if (mem_req_q && mem.mem_ack) begin
          pc_target_d = mem.mem_rdata;
          mem_req_d   = 1'b0;
          sp_inc      = 1'b1;
          done_d      = 1'b1;
          pc_load_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pc_target_q <= '0;
      done_q      <= 1'b0;
      pc_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pc_target_q <= pc_target_d;
      done_q      <= done_d;
      pc_load_q   <= pc_load_d;
    end
  end

`ifdef STACK_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_bounds;
  assign unused_bounds = sp_full ^ sp_empty;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign pc_load       = pc_load_q;
  assign pc_target     = pc_target_q;
  assign sp_out        = sp;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_call_return_unit.sv
// Bench for call_return_unit: table-driven CALL/RET vectors, hand-written
// corner sequences and a randomized run against a stack reference model.
`timescale 1ns/1ps
module tb_call_return_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        call_req, ret_req;
  logic [15:0] ret_addr_in;
  logic        busy, done, pc_load, overflow, underflow;
  logic [15:0] pc_target, sp_out;

  call_return_unit_if #(.ADDR_W(16)) mif ();

  call_return_unit dut (
    .clk         (clk),
    .reset       (reset),
    .call_req    (call_req),
    .ret_req     (ret_req),
    .ret_addr_in (ret_addr_in),
    .busy        (busy),
    .done        (done),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .sp_out      (sp_out),
    .overflow    (overflow),
    .underflow   (underflow),
    .mem         (mif.master)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] mem_b [int];   // memory behind the port
  logic [15:0] mem_m [int];   // reference model's view of the stack contents
  int sp_m;

  typedef struct {
    bit          is_call;
    logic [15:0] data;
    int          lat;
    logic [15:0] e_addr;
    logic [15:0] e_sp;
    logic [15:0] e_pc;
  } vec_t;
  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; call_req = 1'b0; ret_req = 1'b0; ret_addr_in = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // One full CALL or RET with memory answering after lat cycles.
  task automatic do_txn(input bit is_call, input logic [15:0] data, input int lat,
                        input logic [15:0] e_addr, input logic [15:0] e_sp,
                        input logic [15:0] e_pc);
    logic [15:0] a;
    call_req = is_call; ret_req = !is_call; ret_addr_in = data;
    tick();
    call_req = 1'b0; ret_req = 1'b0; ret_addr_in = ~data;
    check("req_start", mif.mem_req, 1);
    check("busy_start", busy, 1);
    check("we", mif.mem_we, is_call);
    check("addr", mif.mem_addr, e_addr);
    if (is_call) check("wdata", mif.mem_wdata, data);
    for (int i = 1; i < lat; i++) begin
      tick();
      check("req_hold", mif.mem_req, 1);
      check("addr_hold", mif.mem_addr, e_addr);
      check("done_early", done, 0);
    end
    a = mif.mem_addr;
    mif.mem_ack = 1'b1;
    if (is_call) mem_b[int'(a)] = mif.mem_wdata;
    else mif.mem_rdata = mem_b.exists(int'(a)) ? mem_b[int'(a)] : 16'hDEAD;
    tick();
    mif.mem_ack = 1'b0;
    check("done", done, 1);
    check("pc_load", pc_load, !is_call);
    check("req_drop", mif.mem_req, 0);
    check("busy_end", busy, 0);
    check("sp", sp_out, e_sp);
    check("no_flow", {overflow, underflow}, 0);
    if (!is_call) check("pc_target", pc_target, e_pc);
    tick();
    check("done_pulse", done, 0);
    check("pc_load_pulse", pc_load, 0);
  endtask

`ifdef STACK_BOUNDS_CHECK_EN
  task automatic do_reject(input bit is_call, input logic [15:0] e_sp);
    call_req = is_call; ret_req = !is_call;
    tick();
    call_req = 1'b0; ret_req = 1'b0;
    check("rej_req", mif.mem_req, 0);
    check("rej_busy", busy, 0);
    check("rej_done", done, 1);
    check("rej_pc_load", pc_load, 0);
    check("rej_flag", {overflow, underflow}, is_call ? 2'b10 : 2'b01);
    check("rej_sp", sp_out, e_sp);
    tick();
    check("rej_done_pulse", done, 0);
    check("rej_flag_pulse", {overflow, underflow}, 0);
    check("rej_sp_hold", sp_out, e_sp);
  endtask
`endif

  initial begin
    vecs[0] = '{1'b1, 16'h0042, 1, 16'h018F, 16'h018E, 16'h0000};
    vecs[1] = '{1'b0, 16'h0000, 1, 16'h018F, 16'h018F, 16'h0042};
    vecs[2] = '{1'b1, 16'h1234, 3, 16'h018F, 16'h018E, 16'h0000};
    vecs[3] = '{1'b1, 16'hBEEF, 2, 16'h018E, 16'h018D, 16'h0000};
    vecs[4] = '{1'b0, 16'h0000, 1, 16'h018E, 16'h018E, 16'hBEEF};
    vecs[5] = '{1'b0, 16'h0000, 4, 16'h018F, 16'h018F, 16'h1234};

    do_reset();
    check("rst_ctrl", {busy, done, pc_load, mif.mem_req, mif.mem_we, overflow, underflow}, 0);
    check("rst_pc_target", pc_target, 0);
    check("rst_addr", mif.mem_addr, 0);
    check("rst_wdata", mif.mem_wdata, 0);
    check("rst_sp", sp_out, 16'h018F);

    foreach (vecs[i])
      do_txn(vecs[i].is_call, vecs[i].data, vecs[i].lat, vecs[i].e_addr, vecs[i].e_sp, vecs[i].e_pc);

    // Back-to-back: RET presented in the CALL's done cycle.
    call_req = 1'b1; ret_addr_in = 16'h1111;
    tick();
    call_req = 1'b0;
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    check("b2b_done", done, 1);
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    check("b2b_req", mif.mem_req, 1);
    check("b2b_we", mif.mem_we, 0);
    check("b2b_addr", mif.mem_addr, 16'h018F);
    mif.mem_ack = 1'b1; mif.mem_rdata = 16'h1111;
    tick();
    mif.mem_ack = 1'b0;
    check("b2b_pc", pc_target, 16'h1111);
    check("b2b_load", pc_load, 1);
    check("b2b_sp", sp_out, 16'h018F);
    tick();

    // Simultaneous call+ret: call wins; a call while busy is dropped.
    call_req = 1'b1; ret_req = 1'b1; ret_addr_in = 16'h7777;
    tick();
    ret_req = 1'b0; ret_addr_in = 16'h9999;
    check("both_we", mif.mem_we, 1);
    check("both_addr", mif.mem_addr, 16'h018F);
    check("both_wdata", mif.mem_wdata, 16'h7777);
    tick();
    call_req = 1'b0;
    check("busy_wdata", mif.mem_wdata, 16'h7777);
    check("busy_req", mif.mem_req, 1);
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    check("both_done", done, 1);
    check("both_sp", sp_out, 16'h018E);
    tick();
    check("no_second_write", mif.mem_req, 0);

    // Reset while a push waits for its ack.
    call_req = 1'b1; ret_addr_in = 16'h5555;
    tick();
    call_req = 1'b0;
    repeat (3) tick();
    check("wait_req", mif.mem_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_req", mif.mem_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sp", sp_out, 16'h018F);
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    check("late_ack_done", done, 0);
    check("late_ack_sp", sp_out, 16'h018F);
    tick();
    check("late_ack_done2", done, 0);

    // Pop from empty stack right after reset.
    do_reset();
`ifdef STACK_BOUNDS_CHECK_EN
    do_reject(1'b0, 16'h018F);
    for (int i = 0; i < 144; i++)
      do_txn(1'b1, 16'(i), 1, 16'(16'h018F - i), 16'(16'h018E - i), 16'h0000);
    check("fill_sp", sp_out, 16'h00FF);
    do_reject(1'b1, 16'h00FF);
`else
    do_txn(1'b0, 16'h0000, 1, 16'h0190, 16'h0190, 16'hDEAD);
`endif

    // Randomized run against the stack model.
    do_reset();
    mem_b.delete();
    mem_m.delete();
    sp_m = 16'h018F;
    for (int n = 0; n < 80; n++) begin
      bit          is_call;
      logic [15:0] data;
      int          lat, a;
      logic [15:0] pc;
      is_call = ($urandom_range(0, 99) < 55);
      data    = 16'($urandom);
      lat     = $urandom_range(1, 4);
`ifdef STACK_BOUNDS_CHECK_EN
      if (is_call && sp_m == 16'h00FF) begin
        do_reject(1'b1, 16'(sp_m));
        continue;
      end
      if (!is_call && sp_m == 16'h018F) begin
        do_reject(1'b0, 16'(sp_m));
        continue;
      end
`endif
      if (is_call) begin
        a = sp_m;
        mem_m[a] = data;
        sp_m = (sp_m - 1) & 16'hFFFF;
        do_txn(1'b1, data, lat, 16'(a), 16'(sp_m), 16'h0000);
      end else begin
        a = (sp_m + 1) & 16'hFFFF;
        pc = mem_m.exists(a) ? mem_m[a] : 16'hDEAD;
        sp_m = a;
        do_txn(1'b0, data, lat, 16'(a), 16'(sp_m), pc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
